pipelined_barrel_shifter: RTL and testbench
===========================================

Name: pipelined_barrel_shifter

Overview:
Parametrised, pipelined successor to the 4-bit combinational barrel shifter. Rotates or shifts a WIDTH-bit word left or right by a run-time amount. Uses one registered mux level per shift-amount bit, with a valid/ready handshake on both sides. Sits between operand sources and the datapath result bus; WIDTH=4 reproduces the original rotate behaviour with latency added.

Parameters:
WIDTH, 8, data width in bits; power of two, 4..64.
AW, $clog2(WIDTH), shift-amount width; localparam, never overridden.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  input word, amount and mode are valid this cycle.
in_ready  output  1  shifter accepts input this cycle.
in_data  input  WIDTH  operand.
in_amt  input  AW  shift/rotate amount, 0..WIDTH-1.
in_mode  input  2  bit0: direction (0=left, 1=right); bit1: kind (0=rotate, 1=shift).
out_valid  output  1  out_data holds a result.
out_ready  input  1  consumer accepts the result this cycle.
out_data  output  WIDTH  result.

Behaviour:
- Reset is synchronous and active-high; clk is the only clock. While rst=1 on a rising edge: every stage valid bit=0, out_valid=0, out_data=0, all stage data/amt/mode registers=0. in_ready=1 in the first cycle after reset is released.
- Pipeline: AW stages. Stage k (k=0..AW-1) moves the word by 2^k positions when amt bit k=1, otherwise passes it through. Each stage registers data, the remaining amt bits, mode and a valid bit. The last stage drives out_data/out_valid directly.
- Latency: exactly AW cycles from an accepted input (in_valid&in_ready on edge N) to out_valid=1 after edge N+AW-1, provided there is no stall. Example: WIDTH=8 gives 3 cycles.
- Throughput: one word per cycle when out_ready=1.
- Advance enable: adv = !out_valid | out_ready. in_ready = adv. When adv=0, every stage holds its contents, including bubbles. The pipeline does not compact bubbles.
- Transfer out: occurs when out_valid&out_ready. out_data stays stable while out_valid=1 and out_ready=0.
- Rotate: bits leaving one end re-enter at the other end; result = in_data rotated by in_amt.
- Shift left: vacated LSBs are filled with 0.
- Shift right: vacated MSBs are filled per the Optional Feature.
- in_amt=0: out_data=in_data for all modes.
- Amount range: the full AW-bit range is legal. No amount reaches WIDTH, so there is no saturation case.
- Simultaneous accept and output transfer in the same cycle is legal and loses no data.
- in_valid=0 while in_ready=1 inserts a bubble (stage valid=0).
- Reset mid-operation flushes all in-flight words. No output is produced for them.
- Inputs are sampled only on an accepting edge. Changes to in_data/in_amt/in_mode while in_ready=0 have no effect.

Optional Feature:
Macro BSHIFT_ARITH_EN.
- Defined: right shift (in_mode=2'b11) is arithmetic; vacated MSBs are copied from the operand's original bit WIDTH-1, which is carried through the stages.
- Undefined: right shift is logical; vacated MSBs are 0.
- Rotate and left-shift behaviour is identical in both builds.

Test Plan:
1. WIDTH=4; rst=1 for 2 cycles, then release -> out_valid=0, out_data=0, in_ready=1.
2. WIDTH=4, out_ready=1; in_data=0001, mode=00, amt=0,1,2,3 on back-to-back cycles -> outputs 0001,0010,0100,1000 on consecutive cycles, first one AW=2 cycles after the first accept.
3. WIDTH=8; in_data=8'b1010_0011, mode=01 (rotate right), amt=3 -> out_data=8'b0111_0100. Same input with mode=10 (shift left), amt=3 -> 8'b0001_1000.
4. WIDTH=8, mode=11, in_data=8'h90, amt=4 -> out_data=8'hF9 with BSHIFT_ARITH_EN defined, 8'h09 without it.
5. Backpressure, WIDTH=8: stream 4 words, hold out_ready=0 for 5 cycles -> in_ready=0 once out_valid=1, out_data held stable, no word lost or duplicated after out_ready returns to 1. Also cover a bubble (in_valid=0 for one cycle) inside the stream.
6. Assert rst for one cycle while 3 words are in flight -> out_valid=0 the next cycle and none of the flushed results ever appear. A new word accepted afterward emerges correctly after AW cycles.

Source files
------------

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one registered mux level per amount bit.
// Define BSHIFT_ARITH_EN to make right shift (mode 2'b11) arithmetic.
module pipelined_barrel_shifter #(
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic w_adv;

  assign w_adv    = !out_valid | out_ready;
  assign in_ready = w_adv;

  for (genvar k = 0; k < AW; k++) begin : g_st
    localparam int S  = 1 << k;
    localparam int RW = AW - k;

    logic [WIDTH-1:0] w_d;
    logic [RW-1:0]    w_a;
    logic [1:0]       w_m;
    logic             w_s;
    logic             w_v;
    logic [WIDTH-1:0] w_rot_l;
    logic [WIDTH-1:0] w_rot_r;
    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_shr;
    logic [WIDTH-1:0] w_mv;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] r_data;
    logic             r_vld;

    if (k == 0) begin : g_src
      assign w_d = in_data;
      assign w_a = in_amt;
      assign w_m = in_mode;
      assign w_v = in_valid;
`ifdef BSHIFT_ARITH_EN
      assign w_s = in_data[WIDTH-1];
`else
      assign w_s = 1'b0;
`endif
    end else begin : g_src
      assign w_d = g_st[k-1].r_data;
      assign w_a = g_st[k-1].g_ctl.r_amt;
      assign w_m = g_st[k-1].g_ctl.r_mode;
      assign w_s = g_st[k-1].g_ctl.r_sign;
      assign w_v = g_st[k-1].r_vld;
    end

    assign w_rot_l = (w_d << S) | (w_d >> (WIDTH - S));
    assign w_rot_r = (w_d >> S) | (w_d << (WIDTH - S));
    assign w_shl   = w_d << S;
    // w_s is the original operand MSB, only ever set in arithmetic builds
    assign w_shr   = (w_d >> S)
                   | (w_s ? ~({WIDTH{1'b1}} >> S) : '0);

    always_comb begin
      w_mv = w_d;
      unique case (w_m)
        2'b00: w_mv = w_rot_l;
        2'b01: w_mv = w_rot_r;
        2'b10: w_mv = w_shl;
        2'b11: w_mv = w_shr;
      endcase
    end

    assign w_res = w_a[0] ? w_mv : w_d;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_data <= '0;
        r_vld  <= 1'b0;
      end else if (w_adv) begin
        r_data <= w_res;
        r_vld  <= w_v;
      end
    end

    if (k < AW - 1) begin : g_ctl
      logic [RW-2:0] r_amt;
      logic [1:0]    r_mode;
      logic          r_sign;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_amt  <= '0;
          r_mode <= '0;
          r_sign <= 1'b0;
        end else if (w_adv) begin
          r_amt  <= w_a[RW-1:1];
          r_mode <= w_m;
          r_sign <= w_s;
        end
      end
    end else begin : g_out
      assign out_data  = r_data;
      assign out_valid = r_vld;
    end
  end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter: WIDTH=4 and WIDTH=8 instances,
// table vectors plus a latency/order scoreboard.
module tb_pipelined_barrel_shifter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       iv4, ir4, ov4, or4;
  logic [3:0] id4, od4;
  logic [1:0] ia4, im4;
  logic       iv8, ir8, ov8, or8;
  logic [7:0] id8, od8;
  logic [2:0] ia8;
  logic [1:0] im8;

  pipelined_barrel_shifter #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst),
    .in_valid(iv4), .in_ready(ir4),
    .in_data(id4), .in_amt(ia4), .in_mode(im4),
    .out_valid(ov4), .out_ready(or4), .out_data(od4)
  );

  pipelined_barrel_shifter #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(ir8),
    .in_data(id8), .in_amt(ia8), .in_mode(im8),
    .out_valid(ov8), .out_ready(or8), .out_data(od8)
  );

  typedef struct {
    logic [7:0] e;
    int         acc;
  } sb_t;

  typedef struct {
    logic [7:0] d;
    logic [2:0] a;
    logic [1:0] m;
    logic [7:0] e;
  } vec_t;

  sb_t  q4[$];
  sb_t  q8[$];
  sb_t  it4, it8;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   chk_lat;
  logic [7:0] hold8;
  bit   hv8;
  vec_t tv[16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] mdl8(input logic [7:0] d,
                                      input logic [2:0] a,
                                      input logic [1:0] m);
    logic [7:0] r;
    logic [7:0] t;
    logic       b;
    int         ai;
    int         src;
    r  = '0;
    ai = int'(a);
    for (int i = 0; i < 8; i++) begin
      b = 1'b0;
      case (m)
        2'b00: begin src = (i - ai + 8) % 8; t = d >> src; b = t[0]; end
        2'b01: begin src = (i + ai) % 8; t = d >> src; b = t[0]; end
        2'b10: if (i >= ai) begin t = d >> (i - ai); b = t[0]; end
        default:
          if (i + ai < 8) begin
            t = d >> (i + ai);
            b = t[0];
          end else begin
`ifdef BSHIFT_ARITH_EN
            b = d[7];
`else
            b = 1'b0;
`endif
          end
      endcase
      r = r | (8'(b) << i);
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q4.delete();
    end else if (ov4 && or4) begin
      if (q4.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious4: got %0h want none", od4);
      end else begin
        it4 = q4.pop_front();
        chk("data4", 64'(od4), 64'(it4.e));
        if (chk_lat) chk("lat4", 64'(cyc), 64'(it4.acc + 1));
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q8.delete();
      hv8 = 1'b0;
    end else begin
      if (ov8 && !or8) begin
        if (hv8) chk("hold8", 64'(od8), 64'(hold8));
        hold8 = od8;
        hv8   = 1'b1;
      end else begin
        hv8 = 1'b0;
      end
      if (ov8 && or8) begin
        if (q8.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious8: got %0h want none", od8);
        end else begin
          it8 = q8.pop_front();
          chk("data8", 64'(od8), 64'(it8.e));
          if (chk_lat) chk("lat8", 64'(cyc), 64'(it8.acc + 2));
        end
      end
    end
  end

  task automatic send4(input logic [3:0] d, input logic [1:0] a,
                       input logic [1:0] m, input logic [3:0] e);
    int  t;
    sb_t s;
    id4 = d; ia4 = a; im4 = m; iv4 = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!ir4 && t < 50);
    if (!ir4) begin
      n_vec++;
      n_err++;
      $display("FAIL accept4: got ready=0 want ready=1");
    end else begin
      s.e = 8'(e);
      s.acc = cyc + 1;
      q4.push_back(s);
    end
    @(posedge clk); #1;
  endtask

  task automatic send8(input logic [7:0] d, input logic [2:0] a,
                       input logic [1:0] m, input logic [7:0] e);
    int  t;
    sb_t s;
    id8 = d; ia8 = a; im8 = m; iv8 = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!ir8 && t < 50);
    if (!ir8) begin
      n_vec++;
      n_err++;
      $display("FAIL accept8: got ready=0 want ready=1");
    end else begin
      s.e = e;
      s.acc = cyc + 1;
      q8.push_back(s);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input bit w8);
    int t;
    t = 0;
    while ((w8 ? q8.size() : q4.size()) != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if ((w8 ? q8.size() : q4.size()) != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain%0d: got %0d pending want 0", w8 ? 8 : 4,
               w8 ? q8.size() : q4.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    logic [2:0] ra;
    logic [1:0] rm;

    tv[0]  = '{8'hA3, 3'd3, 2'b01, 8'h74};
    tv[1]  = '{8'hA3, 3'd3, 2'b10, 8'h18};
`ifdef BSHIFT_ARITH_EN
    tv[2]  = '{8'h90, 3'd4, 2'b11, 8'hF9};
    tv[4]  = '{8'hA3, 3'd3, 2'b11, 8'hF4};
    tv[11] = '{8'h80, 3'd7, 2'b11, 8'hFF};
`else
    tv[2]  = '{8'h90, 3'd4, 2'b11, 8'h09};
    tv[4]  = '{8'hA3, 3'd3, 2'b11, 8'h14};
    tv[11] = '{8'h80, 3'd7, 2'b11, 8'h01};
`endif
    tv[3]  = '{8'hA3, 3'd3, 2'b00, 8'h1D};
    tv[5]  = '{8'hA3, 3'd0, 2'b00, 8'hA3};
    tv[6]  = '{8'hA3, 3'd0, 2'b01, 8'hA3};
    tv[7]  = '{8'hA3, 3'd0, 2'b10, 8'hA3};
    tv[8]  = '{8'hA3, 3'd0, 2'b11, 8'hA3};
    tv[9]  = '{8'h81, 3'd7, 2'b00, 8'hC0};
    tv[10] = '{8'hFF, 3'd7, 2'b10, 8'h80};
    tv[12] = '{8'h01, 3'd1, 2'b01, 8'h80};
    tv[13] = '{8'h7F, 3'd2, 2'b11, 8'h1F};
    tv[14] = '{8'h5A, 3'd5, 2'b00, 8'h4B};
    tv[15] = '{8'h5A, 3'd6, 2'b01, 8'h69};

    rst = 1'b1;
    iv4 = 1'b0; id4 = '0; ia4 = '0; im4 = '0; or4 = 1'b1;
    iv8 = 1'b0; id8 = '0; ia8 = '0; im8 = '0; or8 = 1'b1;
    chk_lat = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_ov4", 64'(ov4), 64'(0));
    chk("rst_od4", 64'(od4), 64'(0));
    chk("rst_ir4", 64'(ir4), 64'(1));
    chk("rst_ov8", 64'(ov8), 64'(0));
    chk("rst_od8", 64'(od8), 64'(0));
    chk("rst_ir8", 64'(ir8), 64'(1));
    @(posedge clk); #1;

    for (int a = 0; a < 4; a++)
      send4(4'b0001, 2'(a), 2'b00, 4'(1 << a));
    send4(4'b1001, 2'd1, 2'b01, 4'b1100);
    send4(4'b0110, 2'd2, 2'b10, 4'b1000);
`ifdef BSHIFT_ARITH_EN
    send4(4'b1000, 2'd3, 2'b11, 4'b1111);
`else
    send4(4'b1000, 2'd3, 2'b11, 4'b0001);
`endif
    iv4 = 1'b0;
    drain(1'b0);

    for (int i = 0; i < 16; i++)
      send8(tv[i].d, tv[i].a, tv[i].m, tv[i].e);
    iv8 = 1'b0;
    drain(1'b1);

    chk_lat = 1'b0;
    or8 = 1'b0;
    send8(8'h3C, 3'd2, 2'b00, mdl8(8'h3C, 3'd2, 2'b00));
    send8(8'hC5, 3'd5, 2'b11, mdl8(8'hC5, 3'd5, 2'b11));
    iv8 = 1'b0;
    @(posedge clk); #1;
    id8 = 8'hE1; ia8 = 3'd1; im8 = 2'b01; iv8 = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_ir8", 64'(ir8), 64'(0));
      chk("stall_ov8", 64'(ov8), 64'(1));
    end
    @(posedge clk); #1;
    or8 = 1'b1;
    send8(8'hE1, 3'd1, 2'b01, mdl8(8'hE1, 3'd1, 2'b01));
    send8(8'h0F, 3'd4, 2'b10, mdl8(8'h0F, 3'd4, 2'b10));
    iv8 = 1'b0;
    drain(1'b1);

    fork
      begin
        for (int i = 0; i < 12; i++) begin
          rd = 8'($urandom);
          ra = 3'($urandom_range(0, 7));
          rm = 2'($urandom);
          send8(rd, ra, rm, mdl8(rd, ra, rm));
        end
        iv8 = 1'b0;
      end
      begin
        repeat (30) begin
          @(posedge clk); #1;
          or8 = 1'($urandom_range(0, 1));
        end
      end
    join
    or8 = 1'b1;
    drain(1'b1);

    chk_lat = 1'b1;
    or8 = 1'b0;
    send8(8'h11, 3'd1, 2'b10, 8'h22);
    send8(8'h22, 3'd2, 2'b10, 8'h88);
    send8(8'h33, 3'd3, 2'b00, 8'h99);
    rst = 1'b1;
    iv8 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("flush_ov8", 64'(ov8), 64'(0));
    chk("flush_od8", 64'(od8), 64'(0));
    chk("flush_ir8", 64'(ir8), 64'(1));
    @(posedge clk); #1;
    or8 = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    send8(8'hB4, 3'd2, 2'b01, 8'h2D);
    iv8 = 1'b0;
    drain(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
